matrix_tx_scheduler: RTL and testbench

//  Sequences transmission of one result matrix (ROWS*COLS bytes) from result memory R out through the UART transmitter.

---
 rtl/matrix_tx_pkg.sv | 43 ++++
 rtl/matrix_tx_scheduler_edge.sv | 22 ++
 rtl/matrix_tx_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_matrix_tx_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_tx_pkg.sv
// Shared encodings for the matrix transmit scheduler: FSM states, frame phases
// and the one-hot front-panel LED patterns.
package matrix_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LATCH,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_NEXT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_HDR,
        PH_DATA,
        PH_TRL
    } phase_t;

    localparam int unsigned LED_W = 5;

    localparam logic [LED_W-1:0] LED_IDLE  = 5'b10000;
    localparam logic [LED_W-1:0] LED_FETCH = 5'b01000;
    localparam logic [LED_W-1:0] LED_SEND  = 5'b00100;
    localparam logic [LED_W-1:0] LED_WAIT  = 5'b00010;
    localparam logic [LED_W-1:0] LED_SEQ   = 5'b00001;

    // Paired states share one LED so the panel shows the coarse activity.
    function automatic logic [LED_W-1:0] led_of(input state_t s);
        logic [LED_W-1:0] led;
        case (s)
            ST_IDLE:                   led = LED_IDLE;
            ST_RD, ST_LATCH:           led = LED_FETCH;
            ST_SEND:                   led = LED_SEND;
            ST_WAIT_ACK, ST_WAIT_DONE: led = LED_WAIT;
            default:                   led = LED_SEQ;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/matrix_tx_scheduler_edge.sv
// Rising-edge detector for the start button: two history flops, so a level held
// high produces exactly one single-cycle pulse.
module tx_start_edge (
    input  logic slow_clk,
    input  logic rst,
    input  logic start,
    output logic rise_c
);

    logic [1:0] hist;

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            hist <= 2'b00;
        end else begin
            hist <= {hist[0], start};
        end
    end

    assign rise_c = hist[0] & ~hist[1];

endmodule

// File: rtl/matrix_tx_scheduler.sv
// Streams one ROWS x COLS result matrix from memory to the UART transmitter,
// framed by optional header/trailer bytes, with ack timeout and abort.
module matrix_tx_scheduler
    import matrix_tx_pkg::*;
#(
    parameter int unsigned        ROWS       = 2,
    parameter int unsigned        COLS       = 2,
    parameter int unsigned        ADDR_W     = 6,
    parameter int unsigned        DATA_W     = 8,
    parameter bit                 HEADER_EN  = 1'b1,
    parameter logic [DATA_W-1:0]  HDR_BYTE   = 8'hAA,
    parameter bit                 TRAILER_EN = 1'b1,
    parameter logic [DATA_W-1:0]  TRL_BYTE   = 8'h55,
    parameter int unsigned        ACK_TO     = 16
) (
    input  logic                slow_clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                tx_busy,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                tx_ready,
    output logic [DATA_W-1:0]   tx_byte,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W+1:0]   byte_cnt,
    output logic [LED_W-1:0]    state_led
);

    localparam int unsigned N    = ROWS * COLS;
    localparam int unsigned TO_W = $clog2(ACK_TO + 1);
    localparam int unsigned BC_W = ADDR_W + 2;

    state_t            state;
    state_t            next_state;
    phase_t            phase;
    logic [ADDR_W-1:0] idx;
    logic [TO_W-1:0]   to_cnt;

    logic start_rise_c;
    logic abort_c;
    logic last_elem_c;
    logic ack_expired_c;

    logic             mem_rd_d;
    logic             tx_ready_d;
    logic             busy_d;
    logic             done_d;
    logic [LED_W-1:0] led_d;

    tx_start_edge u_start_edge (
        .slow_clk (slow_clk),
        .rst      (rst),
        .start    (start),
        .rise_c   (start_rise_c)
    );

    assign abort_c       = abort && (state != ST_IDLE);
    assign last_elem_c   = (idx == ADDR_W'(N - 1));
    assign ack_expired_c = (state == ST_WAIT_ACK) && !tx_busy && (to_cnt <= TO_W'(1));
    assign mem_addr      = idx;

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort_c) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_rise_c) begin
                        next_state = HEADER_EN ? ST_SEND : ST_RD;
                    end
                end
                ST_RD:    next_state = ST_LATCH;
                ST_LATCH: next_state = ST_SEND;
                ST_SEND:  next_state = ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        next_state = ST_WAIT_DONE;
                    end else if (ack_expired_c) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        next_state = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (phase == PH_HDR) begin
                        next_state = ST_RD;
                    end else if (phase == PH_DATA && !last_elem_c) begin
                        next_state = ST_RD;
                    end else if (phase == PH_DATA && TRAILER_EN) begin
                        next_state = ST_SEND;
                    end else begin
                        next_state = ST_DONE;
                    end
                end
                ST_DONE: next_state = ST_IDLE;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the upcoming state, then registered below.
    always_comb begin
        mem_rd_d   = 1'b0;
        tx_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        led_d      = led_of(next_state);
        mem_rd_d   = (next_state == ST_RD);
        tx_ready_d = (next_state == ST_SEND);
        busy_d     = (next_state != ST_IDLE);
        done_d     = (next_state == ST_DONE);
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            mem_rd    <= 1'b0;
            tx_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            state_led <= LED_IDLE;
        end else begin
            mem_rd    <= mem_rd_d;
            tx_ready  <= tx_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            state_led <= led_d;
        end
    end

    // Frame datapath: element index, phase, timeout, byte count and tx byte.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            phase    <= PH_HDR;
            idx      <= '0;
            to_cnt   <= '0;
            tx_byte  <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
        end else if (!abort_c) begin
            case (state)
                ST_IDLE: begin
                    if (start_rise_c) begin
                        byte_cnt <= '0;
                        err      <= 1'b0;
                        idx      <= '0;
                        if (HEADER_EN) begin
                            tx_byte <= HDR_BYTE;
                            phase   <= PH_HDR;
                        end else begin
                            phase   <= PH_DATA;
                        end
                    end
                end
                ST_LATCH: tx_byte <= mem_data;
                ST_SEND:  to_cnt  <= TO_W'(ACK_TO);
                ST_WAIT_ACK: begin
                    if (ack_expired_c) begin
                        err <= 1'b1;
                    end else if (!tx_busy) begin
                        to_cnt <= to_cnt - TO_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        byte_cnt <= byte_cnt + BC_W'(1);
                    end
                end
                ST_NEXT: begin
                    case (phase)
                        PH_HDR: begin
                            phase <= PH_DATA;
                            idx   <= '0;
                        end
                        PH_DATA: begin
                            if (!last_elem_c) begin
                                idx <= idx + ADDR_W'(1);
                            end else if (TRAILER_EN) begin
                                tx_byte <= TRL_BYTE;
                                phase   <= PH_TRL;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_tx_scheduler.sv
// Randomized bench for matrix_tx_scheduler: memory and transmitter models plus a
// frame-level reference of the expected byte stream.
module tb_matrix_tx_scheduler;

    localparam int unsigned N      = 4;
    localparam int unsigned ACK_TO = 16;
    localparam logic [4:0]  L_IDLE = 5'b10000;

    logic       slow_clk = 1'b0;
    logic       rst      = 1'b0;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic       tx_busy  = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic       mem_rd;
    logic [5:0] mem_addr;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] byte_cnt;
    logic [4:0] state_led;

    matrix_tx_scheduler dut (
        .slow_clk  (slow_clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .tx_busy   (tx_busy),
        .mem_data  (mem_data),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .tx_ready  (tx_ready),
        .tx_byte   (tx_byte),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .byte_cnt  (byte_cnt),
        .state_led (state_led)
    );

    always #5 slow_clk = ~slow_clk;

    logic [7:0]  mem   [0:63];
    logic [7:0]  txlog [0:511];
    int unsigned ready_cnt = 0;
    int unsigned done_cnt  = 0;
    int unsigned busy_len  = 10;
    int unsigned ack_lat   = 1;
    bit          xmit_en   = 1'b1;
    bit          pend      = 1'b0;
    int unsigned lat_ctr   = 0;
    int unsigned busy_ctr  = 0;
    int unsigned checks    = 0;
    int unsigned errors    = 0;

    // One-cycle-latency memory; garbage when not read so late latching shows up.
    always @(posedge slow_clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
        else        mem_data <= 8'hEE;
    end

    // Transmitter: busy rises ack_lat cycles after a request, stays busy_len cycles.
    always @(posedge slow_clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (pend) begin
            if (lat_ctr == 0) begin
                pend     <= 1'b0;
                tx_busy  <= 1'b1;
                busy_ctr <= busy_len;
            end else begin
                lat_ctr <= lat_ctr - 1;
            end
        end else if (tx_busy) begin
            if (busy_ctr <= 1) tx_busy <= 1'b0;
            else               busy_ctr <= busy_ctr - 1;
        end
        if (tx_ready) begin
            txlog[ready_cnt] <= tx_byte;
            ready_cnt        <= ready_cnt + 1;
            if (xmit_en) begin
                pend    <= 1'b1;
                lat_ctr <= ack_lat;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference frame: header, elements in address order, trailer.
    function automatic logic [7:0] frame_byte(input int unsigned i);
        logic [7:0] q[$];
        q.push_back(8'hAA);
        for (int j = 0; j < N; j++) q.push_back(mem[j]);
        q.push_back(8'h55);
        return q[i];
    endfunction

    task automatic pulse_start();
        @(negedge slow_clk);
        start = 1'b1;
        @(negedge slow_clk);
        @(negedge slow_clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while ((busy || tx_busy || pend) && n < 2000) begin
            @(negedge slow_clk);
            n++;
        end
        check(tag, n < 2000, 1);
    endtask

    task automatic check_frame(input string tag, input int unsigned b0, input int unsigned d0);
        check({tag, "_nbytes"}, ready_cnt - b0, N + 2);
        for (int i = 0; i < N + 2; i++) check({tag, "_byte"}, txlog[b0 + i], frame_byte(i));
        check({tag, "_byte_cnt"}, byte_cnt, N + 2);
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_err"}, err, 0);
        check({tag, "_led"}, state_led, L_IDLE);
    endtask

    task automatic run_frame(input string tag);
        int unsigned b0 = ready_cnt;
        int unsigned d0 = done_cnt;
        pulse_start();
        wait_idle({tag, "_idle"});
        check_frame(tag, b0, d0);
    endtask

    task automatic abort_frame(input int unsigned k);
        int unsigned b0 = ready_cnt;
        int unsigned d0 = done_cnt;
        int unsigned n  = 0;
        pulse_start();
        while (!(ready_cnt == b0 + k && tx_busy) && n < 500) begin
            @(negedge slow_clk);
            n++;
        end
        check("abort_reach", n < 500, 1);
        @(negedge slow_clk);
        abort = 1'b1;
        @(negedge slow_clk);
        abort = 1'b0;
        check("abort_led", state_led, L_IDLE);
        check("abort_busy", busy, 0);
        check("abort_byte_cnt", byte_cnt, k - 1);
        wait_idle("abort_idle");
        check("abort_done", done_cnt - d0, 0);
        check("abort_nbytes", ready_cnt - b0, k);
    endtask

    initial begin
        int unsigned b0;
        int unsigned d0;
        int unsigned n;

        for (int i = 0; i < 64; i++) mem[i] = 8'(i + 1);

        #2 rst = 1'b1;
        #1;
        check("rst_led", state_led, L_IDLE);
        check("rst_outs", {mem_rd, tx_ready, busy, done, err}, 0);
        check("rst_data", {tx_byte, byte_cnt, mem_addr}, 0);
        repeat (3) @(negedge slow_clk);
        rst = 1'b0;

        // Directed frame with memory 01..04 and 10-cycle bytes.
        run_frame("basic");

        // Random memory contents and transmitter timing.
        for (int it = 0; it < 4; it++) begin
            for (int j = 0; j < N; j++) mem[j] = 8'($urandom);
            busy_len = 1 + $urandom % 12;
            ack_lat  = $urandom % 6;
            run_frame("rand");
        end

        // Start held high for 200 cycles gives exactly one frame.
        busy_len = 10;
        ack_lat  = 1;
        b0 = ready_cnt;
        d0 = done_cnt;
        @(negedge slow_clk);
        start = 1'b1;
        repeat (200) @(negedge slow_clk);
        start = 1'b0;
        wait_idle("held_idle");
        check_frame("held", b0, d0);

        // Second start edge during byte 2 is ignored and not queued.
        b0 = ready_cnt;
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (ready_cnt != b0 + 2 && n < 500) begin
            @(negedge slow_clk);
            n++;
        end
        check("restart_reach", n < 500, 1);
        pulse_start();
        wait_idle("restart_idle");
        check_frame("restart", b0, d0);
        repeat (60) @(negedge slow_clk);
        check("restart_no_queue", ready_cnt - b0, N + 2);

        // Ack timeout: transmitter never responds.
        xmit_en = 1'b0;
        b0 = ready_cnt;
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (!err && n < 100) begin
            @(negedge slow_clk);
            n++;
        end
        check("to_window", (n >= ACK_TO) && (n <= ACK_TO + 2), 1);
        check("to_err", err, 1);
        check("to_led", state_led, L_IDLE);
        check("to_nready", ready_cnt - b0, 1);
        repeat (5) @(negedge slow_clk);
        check("to_done", done_cnt - d0, 0);
        check("to_err_sticky", err, 1);
        xmit_en = 1'b1;
        run_frame("after_to");

        // Abort during WAIT_DONE of a random byte, then a full frame.
        abort_frame(3);
        run_frame("after_abort");
        for (int it = 0; it < 2; it++) begin
            busy_len = 4 + $urandom % 9;
            ack_lat  = $urandom % 4;
            abort_frame(1 + $urandom % (N + 2));
            run_frame("rand_abort_recover");
        end

        // Async reset while the scheduler sits in LATCH.
        busy_len = 10;
        ack_lat  = 1;
        pulse_start();
        n = 0;
        while (!(state_led == 5'b01000 && !mem_rd) && n < 500) begin
            @(negedge slow_clk);
            n++;
        end
        check("latch_reach", n < 500, 1);
        rst = 1'b1;
        #1;
        check("arst_led", state_led, L_IDLE);
        check("arst_outs", {mem_rd, tx_ready, busy, done, err}, 0);
        check("arst_data", {tx_byte, byte_cnt, mem_addr}, 0);
        @(negedge slow_clk);
        rst = 1'b0;
        wait_idle("arst_idle");
        run_frame("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
